requan3_stage: RTL and testbench

Three-stage pipelined requantizer for the DLA output path. It converts a signed 32-bit convolution accumulator into a saturated signed 16-bit (`HWORD`) activation using bias, fixed-point multiplier, rounding shift, zero point and optional ReLU. Its `requan_result` output drives `Requan3_result_in` of the writeback register, and its `stall` input is the same stall that register receives.

---
 rtl/requan3_stage.sv | 88 ++++++++
 tb/tb_requan3_stage.sv | 122 ++++++++++++
 2 files changed

// File: rtl/requan3_stage.sv
// requan3_stage: three-stage requantizer, int32 accumulator to saturated int16 activation.
module requan3_stage #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             in_valid,
    input  logic [ACC_W-1:0] acc_in,
    input  logic [ACC_W-1:0] bias,
    input  logic [ACC_W-1:0] mult,
    input  logic [4:0]       shift,
    input  logic [OUT_W-1:0] zero_point,
    input  logic             relu_en,
    output logic             out_valid,
    output logic [OUT_W-1:0] requan_result
);
    localparam int PW = 2 * ACC_W;
    localparam logic signed [PW-1:0] WMAX = (64'sd1 <<< (OUT_W - 1)) - 64'sd1;
    localparam logic signed [PW-1:0] WMIN = -(64'sd1 <<< (OUT_W - 1));

    logic                    v1, v2;
    logic [ACC_W-1:0]        sum1, mult1;
    logic [4:0]              sh1, sh2;
    logic [OUT_W-1:0]        zp1, zp2;
    logic                    relu1, relu2;
    logic signed [PW-1:0]    prod2;

    logic [ACC_W:0]          sum_w;
    logic [ACC_W-1:0]        sat_w;
    logic signed [PW-1:0]    prod_w, rnd, r, zp_w, t_w, t_r;
    logic [6:0]              n;
    logic [OUT_W-1:0]        res_w;

    always_comb begin
        sum_w  = {acc_in[ACC_W-1], acc_in} + {bias[ACC_W-1], bias};
        sat_w  = (sum_w[ACC_W] != sum_w[ACC_W-1]) ? {sum_w[ACC_W], {(ACC_W-1){~sum_w[ACC_W]}}}
                                                  : sum_w[ACC_W-1:0];
        prod_w = $signed({{ACC_W{sum1[ACC_W-1]}}, sum1}) * $signed({{ACC_W{mult1[ACC_W-1]}}, mult1});
        n      = 7'd31 + {2'b00, sh2};
        rnd    = {{(PW-1){1'b0}}, 1'b1} << (n - 7'd1);
        r      = (prod2 + rnd) >>> n;
        zp_w   = {{(PW-OUT_W){zp2[OUT_W-1]}}, zp2};
        t_w    = r + zp_w;
        t_r    = (relu2 && t_w < zp_w) ? zp_w : t_w;
        res_w  = t_r > WMAX ? {1'b0, {(OUT_W-1){1'b1}}} :
                 t_r < WMIN ? {1'b1, {(OUT_W-1){1'b0}}} : t_r[OUT_W-1:0];
    end

    // Valid bits advance every unstalled cycle; data loads only behind a valid beat.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1            <= 1'b0;
            v2            <= 1'b0;
            out_valid     <= 1'b0;
            requan_result <= '0;
            sum1          <= '0;
            mult1         <= '0;
            sh1           <= '0;
            zp1           <= '0;
            relu1         <= 1'b0;
            prod2         <= '0;
            sh2           <= '0;
            zp2           <= '0;
            relu2         <= 1'b0;
        end else if (!stall) begin
            v1        <= in_valid;
            v2        <= v1;
            out_valid <= v2;
            if (in_valid) begin
                sum1  <= sat_w;
                mult1 <= mult;
                sh1   <= shift;
                zp1   <= zero_point;
                relu1 <= relu_en;
            end
            if (v1) begin
                prod2 <= prod_w;
                sh2   <= sh1;
                zp2   <= zp1;
                relu2 <= relu1;
            end
            if (v2)
                requan_result <= res_w;
        end
    end
endmodule

// File: tb/tb_requan3_stage.sv
// tb_requan3_stage: directed checks of requan3_stage with hand-computed results.
module tb_requan3_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] acc_in = '0;
    logic [31:0] bias = '0;
    logic [31:0] mult = '0;
    logic [4:0]  shift = '0;
    logic [15:0] zero_point = '0;
    logic        relu_en = 1'b0;
    logic        out_valid;
    logic [15:0] requan_result;
    int          n_cmp = 0;
    int          n_err = 0;

    requan3_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .in_valid(in_valid),
        .acc_in(acc_in), .bias(bias), .mult(mult), .shift(shift),
        .zero_point(zero_point), .relu_en(relu_en),
        .out_valid(out_valid), .requan_result(requan_result)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated beat: result appears on the third edge after it is presented, then holds.
    task automatic send(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] m, input logic [4:0] s, input logic [15:0] z,
                        input logic r, input logic [15:0] exp);
        acc_in = a; bias = b; mult = m; shift = s; zero_point = z; relu_en = r;
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        chk({tag, ".ov_early"}, {31'b0, out_valid}, 32'd0);
        tick;
        chk({tag, ".ov"}, {31'b0, out_valid}, 32'd1);
        chk({tag, ".res"}, {16'b0, requan_result}, {16'b0, exp});
        tick;
        chk({tag, ".ov_drop"}, {31'b0, out_valid}, 32'd0);
        chk({tag, ".hold"}, {16'b0, requan_result}, {16'b0, exp});
    endtask

    initial begin
        tick;
        tick;
        chk("reset.ov", {31'b0, out_valid}, 32'd0);
        chk("reset.res", {16'b0, requan_result}, 32'd0);
        rst = 1'b1;

        send("basic",    32'd1000,      32'd0, 32'h40000000, 5'd0, 16'd0,  1'b0, 16'h01F4);
        send("rnd_pos",  32'd3,         32'd0, 32'h40000000, 5'd0, 16'd0,  1'b0, 16'h0002);
        send("rnd_neg",  -32'sd3,       32'd0, 32'h40000000, 5'd0, 16'd0,  1'b0, 16'hFFFF);
        send("shift2",   32'd1000,      32'd0, 32'h40000000, 5'd2, 16'd0,  1'b0, 16'h007D);
        send("sat_hi",   32'h7FFFFFFF,  32'd1, 32'h7FFFFFFF, 5'd0, 16'd0,  1'b0, 16'h7FFF);
        send("sat_lo",   -32'sd100000,  32'd0, 32'h40000000, 5'd0, 16'd0,  1'b0, 16'h8000);
        send("relu_on",  -32'sd200,     32'd0, 32'h40000000, 5'd0, 16'd10, 1'b1, 16'h000A);
        send("relu_off", -32'sd200,     32'd0, 32'h40000000, 5'd0, 16'd10, 1'b0, 16'hFFA6);

        // Stream 2,4,6 with a two-cycle stall after the second beat.
        mult = 32'h40000000; shift = 5'd0; zero_point = 16'd0; relu_en = 1'b0; bias = 32'd0;
        acc_in = 32'd2; in_valid = 1'b1;
        tick;
        acc_in = 32'd4;
        tick;
        acc_in = 32'd6; stall = 1'b1;
        tick;
        chk("stall1.ov", {31'b0, out_valid}, 32'd0);
        chk("stall1.res", {16'b0, requan_result}, 32'h0000FFA6);
        tick;
        chk("stall2.ov", {31'b0, out_valid}, 32'd0);
        chk("stall2.res", {16'b0, requan_result}, 32'h0000FFA6);
        stall = 1'b0;
        tick;
        in_valid = 1'b0;
        chk("strm1.ov", {31'b0, out_valid}, 32'd1);
        chk("strm1.res", {16'b0, requan_result}, 32'd1);
        tick;
        chk("strm2.ov", {31'b0, out_valid}, 32'd1);
        chk("strm2.res", {16'b0, requan_result}, 32'd2);
        tick;
        chk("strm3.ov", {31'b0, out_valid}, 32'd1);
        chk("strm3.res", {16'b0, requan_result}, 32'd3);
        tick;
        chk("strm_end.ov", {31'b0, out_valid}, 32'd0);
        chk("strm_end.res", {16'b0, requan_result}, 32'd3);

        // Two beats in flight, then reset while stalled.
        acc_in = 32'd1000; in_valid = 1'b1;
        tick;
        acc_in = 32'd3;
        tick;
        in_valid = 1'b0; stall = 1'b1; rst = 1'b0;
        tick;
        chk("midrst.ov", {31'b0, out_valid}, 32'd0);
        chk("midrst.res", {16'b0, requan_result}, 32'd0);
        rst = 1'b1; stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick;
            chk("postrst.ov", {31'b0, out_valid}, 32'd0);
            chk("postrst.res", {16'b0, requan_result}, 32'd0);
        end
        send("fresh", 32'd1000, 32'd0, 32'h40000000, 5'd0, 16'd0, 1'b0, 16'h01F4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
